// File: rtl/vgg_block_seq.sv
// Layer/kernel sequencer for one VGG block: walks every conv layer and kernel on a shared
// conv engine, optionally runs one maxpool pass, and drives ping-pong buffer selection.
module vgg_block_seq #(
    parameter int DATA_WIDTH        = 32,
    parameter int IMAGE_WIDTH       = 7,
    parameter int NUM_CONV          = 3,
    parameter int NUMBER_OF_CHANNEL = 64,
    parameter int NUMBER_OF_KERNEL  = 64,
    parameter int POOL_EN           = 1,
    localparam int KW = (NUMBER_OF_KERNEL > 1) ? $clog2(NUMBER_OF_KERNEL) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_valid,
    output logic          o_valid,
    output logic          o_busy,
    output logic          o_conv_start,
    input  logic          i_conv_done,
    output logic          o_pool_start,
    input  logic          i_pool_done,
    output logic [1:0]    o_layer,
    output logic [KW-1:0] o_kernel,
    output logic [15:0]   o_num_ch,
    output logic [15:0]   o_img_w,
    output logic          o_src_buf,
    output logic          o_err
);

    typedef enum logic [2:0] {
        IDLE,
        CSTART,
        CWAIT,
        PSTART,
        PWAIT,
        DONE
    } state_t;

    localparam logic [KW-1:0] KERNEL_LAST = KW'(NUMBER_OF_KERNEL - 1);
    localparam logic [1:0]    LAYER_LAST  = 2'(NUM_CONV - 1);

    state_t          state, state_d;
    logic [1:0]      layer_d;
    logic [KW-1:0]   kernel_d;
    logic            src_d;
    logic            err_d;
    logic            valid_d;
    logic            busy_d;
    logic            conv_start_d;
    logic            pool_start_d;
    logic [15:0]     num_ch_d;

    assign o_img_w = 16'(IMAGE_WIDTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            o_valid      <= 1'b0;
            o_busy       <= 1'b0;
            o_conv_start <= 1'b0;
            o_pool_start <= 1'b0;
            o_layer      <= '0;
            o_kernel     <= '0;
            o_src_buf    <= 1'b0;
            o_err        <= 1'b0;
            o_num_ch     <= 16'(NUMBER_OF_CHANNEL);
        end else begin
            state        <= state_d;
            o_valid      <= valid_d;
            o_busy       <= busy_d;
            o_conv_start <= conv_start_d;
            o_pool_start <= pool_start_d;
            o_layer      <= layer_d;
            o_kernel     <= kernel_d;
            o_src_buf    <= src_d;
            o_err        <= err_d;
            o_num_ch     <= num_ch_d;
        end
    end

    always_comb begin
        state_d  = state;
        layer_d  = o_layer;
        kernel_d = o_kernel;
        src_d    = o_src_buf;
        err_d    = o_err;
        case (state)
            IDLE: begin
                if (i_valid) begin
                    state_d  = CSTART;
                    layer_d  = '0;
                    kernel_d = '0;
                    src_d    = 1'b0;
                    err_d    = 1'b0;
                end
            end
            CSTART: state_d = CWAIT;
            CWAIT: begin
                if (i_conv_done) begin
                    if (o_kernel != KERNEL_LAST) begin
                        kernel_d = o_kernel + 1'b1;
                        state_d  = CSTART;
                    end else begin
                        src_d = ~o_src_buf;
                        if (o_layer != LAYER_LAST) begin
                            kernel_d = '0;
                            layer_d  = o_layer + 2'd1;
                            state_d  = CSTART;
                        end else begin
                            state_d = (POOL_EN != 0) ? PSTART : DONE;
                        end
                    end
                end
            end
            PSTART: state_d = PWAIT;
            PWAIT: begin
                // The pool pass also writes the opposite buffer, so the select follows its output.
                if (i_pool_done) begin
                    state_d = DONE;
                    src_d   = ~o_src_buf;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if ((i_conv_done && state != CWAIT) || (i_pool_done && state != PWAIT)) begin
            err_d = 1'b1;
        end
    end

    always_comb begin
        conv_start_d = (state_d == CSTART);
        pool_start_d = (state_d == PSTART);
        valid_d      = (state_d == DONE);
        busy_d       = (state_d != IDLE);
        num_ch_d     = (layer_d == 2'd0) ? 16'(NUMBER_OF_CHANNEL) : 16'(NUMBER_OF_KERNEL);
    end

endmodule

// File: tb/tb_vgg_block_seq.sv
// Bench for vgg_block_seq: two configurations driven by a scripted engine with random latency,
// checked against a layer/kernel enumeration model of the block schedule.
module tb_vgg_block_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic valid [2];
    logic cdone [2];
    logic pdone [2];
    int   vhold [2];

    logic        a_ov, a_busy, a_cs, a_ps, a_src, a_err;
    logic [1:0]  a_layer;
    logic [0:0]  a_kernel;
    logic [15:0] a_nch, a_imgw;
    logic        b_ov, b_busy, b_cs, b_ps, b_src, b_err;
    logic [1:0]  b_layer;
    logic [5:0]  b_kernel;
    logic [15:0] b_nch, b_imgw;

    logic        ov [2], busy [2], cs [2], ps [2], src [2], err [2];
    logic [1:0]  lay [2];
    logic [7:0]  ker [2];
    logic [15:0] nch [2], imgw [2];

    int cs_cnt [2] = '{0, 0};
    int ps_cnt [2] = '{0, 0};
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    vgg_block_seq #(.IMAGE_WIDTH(7), .NUM_CONV(2), .NUMBER_OF_CHANNEL(5),
                    .NUMBER_OF_KERNEL(2), .POOL_EN(1)) dut_a (
        .clk(clk), .rst(rst), .i_valid(valid[0]), .o_valid(a_ov), .o_busy(a_busy),
        .o_conv_start(a_cs), .i_conv_done(cdone[0]), .o_pool_start(a_ps),
        .i_pool_done(pdone[0]), .o_layer(a_layer), .o_kernel(a_kernel), .o_num_ch(a_nch),
        .o_img_w(a_imgw), .o_src_buf(a_src), .o_err(a_err));

    vgg_block_seq #(.IMAGE_WIDTH(7), .NUM_CONV(3), .NUMBER_OF_CHANNEL(3),
                    .NUMBER_OF_KERNEL(64), .POOL_EN(0)) dut_b (
        .clk(clk), .rst(rst), .i_valid(valid[1]), .o_valid(b_ov), .o_busy(b_busy),
        .o_conv_start(b_cs), .i_conv_done(cdone[1]), .o_pool_start(b_ps),
        .i_pool_done(pdone[1]), .o_layer(b_layer), .o_kernel(b_kernel), .o_num_ch(b_nch),
        .o_img_w(b_imgw), .o_src_buf(b_src), .o_err(b_err));

    always_comb begin
        ov[0] = a_ov;    busy[0] = a_busy;  cs[0] = a_cs;    ps[0] = a_ps;
        src[0] = a_src;  err[0] = a_err;    lay[0] = a_layer; ker[0] = 8'(a_kernel);
        nch[0] = a_nch;  imgw[0] = a_imgw;
        ov[1] = b_ov;    busy[1] = b_busy;  cs[1] = b_cs;    ps[1] = b_ps;
        src[1] = b_src;  err[1] = b_err;    lay[1] = b_layer; ker[1] = 8'(b_kernel);
        nch[1] = b_nch;  imgw[1] = b_imgw;
    end

    always @(negedge clk) begin
        if (a_cs) cs_cnt[0]++;
        if (b_cs) cs_cnt[1]++;
        if (a_ps) ps_cnt[0]++;
        if (b_ps) ps_cnt[1]++;
    end

    function automatic int ncv(input int id);  return (id == 0) ? 2 : 3;  endfunction
    function automatic int kv(input int id);   return (id == 0) ? 2 : 64; endfunction
    function automatic int chv(input int id);  return (id == 0) ? 5 : 3;  endfunction
    function automatic int plv(input int id);  return (id == 0) ? 1 : 0;  endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (vhold[i] > 0) begin
                vhold[i]--;
                if (vhold[i] == 0) valid[i] = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            valid[i] = 1'b0; cdone[i] = 1'b0; pdone[i] = 1'b0; vhold[i] = 0;
        end
        tick(); tick();
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if ({ov[i], busy[i], cs[i], ps[i], src[i], err[i], lay[i], ker[i]} !== 16'h0) begin
                miscompares++;
                $display("FAIL reset_outs dut%0d: got ov%b busy%b cs%b ps%b src%b err%b l%0d k%0d, want all 0",
                         i, ov[i], busy[i], cs[i], ps[i], src[i], err[i], lay[i], ker[i]);
            end
            vectors++;
            if (nch[i] !== 16'(chv(i)) || imgw[i] !== 16'd7) begin
                miscompares++;
                $display("FAIL reset_consts dut%0d: got nch %0d imgw %0d, want %0d 7",
                         i, nch[i], imgw[i], chv(i));
            end
        end
        rst = 1'b0;
        tick();
    endtask

    // lat < 0 picks a random engine latency (1..4 cycles after each start) per kernel.
    task automatic run_block(input int id, input int hold, input int lat);
        int nc, k, ch, pl, total, base_cs, base_ps, l, kk, d;
        nc = ncv(id); k = kv(id); ch = chv(id); pl = plv(id);
        total = nc * k;
        base_cs = cs_cnt[id]; base_ps = ps_cnt[id];
        valid[id] = 1'b1;
        vhold[id] = hold;
        tick();
        for (int n = 0; n < total; n++) begin
            l = n / k; kk = n % k;
            vectors++;
            if ({cs[id], busy[id], ov[id], ps[id], err[id]} !== 5'b11000 ||
                lay[id] !== 2'(l) || ker[id] !== 8'(kk) || src[id] !== 1'(l % 2) ||
                nch[id] !== 16'((l == 0) ? ch : k)) begin
                miscompares++;
                $display("FAIL conv_start dut%0d #%0d: got cs%b busy%b ov%b ps%b err%b l%0d k%0d src%b nch%0d, want 11000 l%0d k%0d src%0d nch%0d",
                         id, n, cs[id], busy[id], ov[id], ps[id], err[id], lay[id], ker[id],
                         src[id], nch[id], l, kk, l % 2, (l == 0) ? ch : k);
            end
            tick();
            vectors++;
            if (cs[id] !== 1'b0) begin
                miscompares++;
                $display("FAIL conv_pulse_width dut%0d #%0d: got cs %b, want 0", id, n, cs[id]);
            end
            d = (lat > 0) ? lat : int'($urandom_range(1, 4));
            repeat (d - 1) tick();
            cdone[id] = 1'b1;
            tick();
            cdone[id] = 1'b0;
        end
        if (pl != 0) begin
            vectors++;
            if ({ps[id], cs[id], ov[id]} !== 3'b100 || src[id] !== 1'(nc % 2)) begin
                miscompares++;
                $display("FAIL pool_start dut%0d: got ps%b cs%b ov%b src%b, want 100 src%0d",
                         id, ps[id], cs[id], ov[id], src[id], nc % 2);
            end
            tick();
            repeat ($urandom_range(0, 2)) tick();
            pdone[id] = 1'b1;
            tick();
            pdone[id] = 1'b0;
        end
        vectors++;
        if ({ov[id], busy[id], cs[id], ps[id]} !== 4'b1100) begin
            miscompares++;
            $display("FAIL done_pulse dut%0d: got ov%b busy%b cs%b ps%b, want 1100",
                     id, ov[id], busy[id], cs[id], ps[id]);
        end
        tick();
        vectors++;
        if ({ov[id], busy[id], err[id]} !== 3'b000 || lay[id] !== 2'(nc - 1) ||
            ker[id] !== 8'(k - 1) || src[id] !== 1'((nc + pl) % 2)) begin
            miscompares++;
            $display("FAIL final_state dut%0d: got ov%b busy%b err%b l%0d k%0d src%b, want 000 l%0d k%0d src%0d",
                     id, ov[id], busy[id], err[id], lay[id], ker[id], src[id], nc - 1, k - 1,
                     (nc + pl) % 2);
        end
        repeat (3) tick();
        vectors++;
        if (cs_cnt[id] - base_cs !== total || ps_cnt[id] - base_ps !== pl || busy[id] !== 1'b0) begin
            miscompares++;
            $display("FAIL start_counts dut%0d: got conv %0d pool %0d busy %b, want %0d %0d 0",
                     id, cs_cnt[id] - base_cs, ps_cnt[id] - base_ps, busy[id], total, pl);
        end
    endtask

    task automatic test_err_idle();
        cdone[0] = 1'b1;
        tick();
        cdone[0] = 1'b0;
        vectors++;
        if ({err[0], busy[0], cs[0], ps[0]} !== 4'b1000) begin
            miscompares++;
            $display("FAIL err_idle_conv: got err%b busy%b cs%b ps%b, want 1000",
                     err[0], busy[0], cs[0], ps[0]);
        end
        pdone[1] = 1'b1;
        tick();
        pdone[1] = 1'b0;
        tick();
        vectors++;
        if ({err[1], busy[1], cs[1], err[0], busy[0]} !== 5'b10010) begin
            miscompares++;
            $display("FAIL err_idle_pool: got b err%b busy%b cs%b a err%b busy%b, want 10010",
                     err[1], busy[1], cs[1], err[0], busy[0]);
        end
    endtask

    task automatic test_both_done();
        valid[0] = 1'b1; vhold[0] = 1;
        tick(); tick();
        cdone[0] = 1'b1; pdone[0] = 1'b1;
        tick();
        cdone[0] = 1'b0; pdone[0] = 1'b0;
        vectors++;
        if (ker[0] !== 8'd1 || lay[0] !== 2'd0 || {err[0], cs[0], ps[0]} !== 3'b110) begin
            miscompares++;
            $display("FAIL both_done: got l%0d k%0d err%b cs%b ps%b, want l0 k1 110",
                     lay[0], ker[0], err[0], cs[0], ps[0]);
        end
        rst = 1'b1; tick(); rst = 1'b0; tick();
    endtask

    task automatic test_reset_mid();
        int base;
        valid[0] = 1'b1; vhold[0] = 1;
        tick();
        repeat (2) begin
            tick();
            cdone[0] = 1'b1; tick(); cdone[0] = 1'b0;
        end
        tick();
        vectors++;
        if (lay[0] !== 2'd1 || cs[0] !== 1'b0 || busy[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_setup: got l%0d cs%b busy%b, want l1 cs0 busy1", lay[0], cs[0], busy[0]);
        end
        rst = 1'b1;
        tick();
        vectors++;
        if ({ov[0], busy[0], cs[0], ps[0], src[0], err[0], lay[0], ker[0]} !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_mid: got ov%b busy%b cs%b ps%b src%b err%b l%0d k%0d, want all 0",
                     ov[0], busy[0], cs[0], ps[0], src[0], err[0], lay[0], ker[0]);
        end
        rst = 1'b0;
        tick();
        base = cs_cnt[0] + ps_cnt[0];
        cdone[0] = 1'b1; tick(); cdone[0] = 1'b0;
        repeat (3) tick();
        vectors++;
        if ({err[0], busy[0], cs[0], ov[0]} !== 4'b1000 || cs_cnt[0] + ps_cnt[0] !== base) begin
            miscompares++;
            $display("FAIL post_reset_done: got err%b busy%b cs%b ov%b starts+%0d, want 1000 +0",
                     err[0], busy[0], cs[0], ov[0], cs_cnt[0] + ps_cnt[0] - base);
        end
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 4; r++) begin
            run_block(0, 1, -1);
        end
        run_block(1, 1, -1);
    endtask

    initial begin
        test_reset();
        run_block(0, 1, 3);
        run_block(1, 5, -1);
        test_err_idle();
        run_block(0, 1, -1);
        test_both_done();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
